// File: rtl/ram_seq_reader_if.sv
// ============================================================================
// Module   : ram_seq_reader_if
// Purpose  : Command, RAM-port and output-stream signals of the sequential
//            RAM reader, with reader (master) and environment (slave) views.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ram_seq_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) ();
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   len;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;

  modport master (
    input  start, base_addr, len, mem_q, rd_ready,
    output busy, done, mem_addr, rd_data, rd_valid
  );

  modport slave (
    output start, base_addr, len, mem_q, rd_ready,
    input  busy, done, mem_addr, rd_data, rd_valid
  );
endinterface

`default_nettype wire

// File: rtl/ram_seq_reader.sv
// ============================================================================
// Module   : ram_seq_reader
// Purpose  : Reads len consecutive words from a 1-cycle-latency synchronous RAM
//            and streams them out through a 2-entry valid/ready buffer.
//            Optional running checksum enabled by SEQ_RD_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_seq_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SEQ_RD_CHECKSUM_EN
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] checksum,
`endif
  ram_seq_reader_if.master bus
);

  localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_to_issue;
  logic [ADDR_WIDTH:0]   r_to_deliver;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic                  r_done;
  logic                  w_issue;
  logic                  w_done_set;
  logic                  w_pop;
  logic                  w_start_ok;
  logic                  w_room;

  assign w_pop      = (r_occ != 2'd0) && bus.rd_ready;
  assign w_start_ok = (r_state == ST_IDLE) && bus.start && (bus.len != '0);
  // Only issue if the word would still fit once it lands next cycle.
  assign w_room     = ({1'b0, r_occ} + {2'b00, r_inflight}) <= (3'd1 + {2'b00, w_pop});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            w_next_state = ST_FETCH;
          end else begin
            w_done_set = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        w_issue = w_room;
        if (w_issue && (r_to_issue == c_CNT_ONE)) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_pop && (r_to_deliver == c_CNT_ONE)) begin
          w_next_state = ST_IDLE;
          w_done_set   = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_to_issue   <= '0;
      r_to_deliver <= '0;
      r_inflight   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= w_done_set;
      if (w_start_ok) begin
        r_addr       <= bus.base_addr;
        r_to_issue   <= bus.len;
        r_to_deliver <= bus.len;
      end else begin
        if (w_issue) begin
          r_to_issue <= r_to_issue - c_CNT_ONE;
          // The final address is left on the bus rather than advanced.
          if (r_to_issue != c_CNT_ONE) begin
            r_addr <= r_addr + c_ADDR_ONE;
          end
        end
        if (w_pop) begin
          r_to_deliver <= r_to_deliver - c_CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_occ  <= 2'd0;
    end else if (r_inflight && w_pop) begin
      if (r_occ == 2'd1) begin
        r_buf0 <= bus.mem_q;
      end else begin
        r_buf0 <= r_buf1;
        r_buf1 <= bus.mem_q;
      end
    end else if (r_inflight) begin
      if (r_occ == 2'd0) begin
        r_buf0 <= bus.mem_q;
      end else begin
        r_buf1 <= bus.mem_q;
      end
      r_occ <= r_occ + 2'd1;
    end else if (w_pop) begin
      r_buf0 <= r_buf1;
      r_occ  <= r_occ - 2'd1;
    end
  end

`ifdef SEQ_RD_CHECKSUM_EN
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if ((r_state == ST_IDLE) && bus.start) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum + {{ADDR_WIDTH{1'b0}}, r_buf0};
    end
  end

  assign checksum = r_checksum;
`endif

  assign bus.mem_addr = r_addr;
  assign bus.rd_data  = r_buf0;
  assign bus.rd_valid = (r_occ != 2'd0);
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ram_seq_reader.sv
// ============================================================================
// Module   : tb_ram_seq_reader
// Purpose  : Directed and randomized checks of ram_seq_reader against a queue
//            based reference of the expected word stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_seq_reader;

  logic clk;
  logic rst_n;
  logic [7:0] mem [0:1023];
  int n_checks;
  int n_pass;
  int n_fail;
  int dc;

`ifdef SEQ_RD_CHECKSUM_EN
  logic [17:0] checksum;
`endif

  ram_seq_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus ();

  ram_seq_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SEQ_RD_CHECKSUM_EN
    .checksum (checksum),
`endif
    .bus      (bus.master)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) bus.mem_q <= mem[bus.mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  // mode 0: always ready, 1: 1,0,0 pattern, 2: random.  poke re-asserts start mid-transfer.
  task automatic run_xfer(input logic [9:0] base, input logic [10:0] n, input int mode,
                          input bit poke, output int done_cyc);
    logic [7:0]  exp_q[$];
    logic [17:0] sum;
    logic [7:0]  prev_data;
    logic        prev_stall;
    int          got;
    int          cyc;
    sum = '0; prev_data = '0; prev_stall = 1'b0; got = 0; done_cyc = -1;
    for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[(int'(base) + i) % 1024]);
    bus.base_addr = base;
    bus.len       = n;
    bus.start     = 1'b1;
    bus.rd_ready  = pick_ready(mode, 0);
    tick();
    cyc = 1;
    while (cyc < 5000) begin
      bus.start    = poke && (cyc == 2);
      if (bus.start) begin
        bus.base_addr = 10'($urandom);
        bus.len       = 11'd5;
      end
      bus.rd_ready = pick_ready(mode, cyc);
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == 1) check("busy_after_start", bus.busy, 1);
      if (mode == 0 && n <= 8 && cyc <= int'(n))
        check("mem_addr_seq", bus.mem_addr, (int'(base) + cyc - 1) % 1024);
      if (prev_stall) begin
        check("stall_valid", bus.rd_valid, 1);
        check("stall_data", bus.rd_data, prev_data);
      end
      if (bus.rd_valid && bus.rd_ready) begin
        got++;
        if (exp_q.size() == 0) check("extra_word", got, n);
        else begin
          check("rd_data", bus.rd_data, exp_q[0]);
          sum += 18'(exp_q.pop_front());
        end
      end
      prev_stall = bus.rd_valid && !bus.rd_ready;
      prev_data  = bus.rd_data;
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    check("done_seen", done_cyc != -1, 1);
    check("word_count", got, n);
    check("busy_at_done", bus.busy, 0);
    if (mode == 0) check("done_cycle", done_cyc, int'(n) + 3);
`ifdef SEQ_RD_CHECKSUM_EN
    check("checksum_done", checksum, sum);
`endif
    tick();
    check("done_pulse_len", bus.done, 0);
    check("idle_valid", bus.rd_valid, 0);
`ifdef SEQ_RD_CHECKSUM_EN
    check("checksum_stable", checksum, sum);
`endif
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    rst_n = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.rd_ready = 1'b0;
    tick(); tick();
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rst_n = 1'b1;
    tick();

    // Exact cycle timing of a 4-word transfer.
    bus.base_addr = 10'h010; bus.len = 11'd4; bus.start = 1'b1; bus.rd_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4) check("t1_mem_addr", bus.mem_addr, 32'h10 + c - 1);
      check("t1_rd_valid", bus.rd_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check("t1_rd_data", bus.rd_data, 32'h10 + c - 3);
      check("t1_done", bus.done, c == 7);
      check("t1_busy", bus.busy, c < 7);
      tick();
    end

    run_xfer(10'h3FE, 11'd4, 0, 1'b0, dc);
    run_xfer(10'h010, 11'd3, 1, 1'b0, dc);

    // Zero-length request.
    bus.base_addr = 10'h155; bus.len = 11'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("len0_done", bus.done, 1);
    check("len0_busy", bus.busy, 0);
    check("len0_mem_addr", bus.mem_addr, 32'h012);
`ifdef SEQ_RD_CHECKSUM_EN
    check("len0_checksum", checksum, 0);
`endif
    tick();
    check("len0_done_pulse", bus.done, 0);

    // Reset in the middle of a transfer after two words.
    bus.base_addr = 10'h010; bus.len = 11'd8; bus.start = 1'b1; bus.rd_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    check("pre_rst_valid", bus.rd_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_mem_addr", bus.mem_addr, 0);
    check("arst_rd_data", bus.rd_data, 0);
    check("arst_rd_valid", bus.rd_valid, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", bus.rd_valid, 0);
    run_xfer(10'h020, 11'd2, 0, 1'b0, dc);

    // Whole RAM, full throughput.
    run_xfer(10'h000, 11'd1024, 0, 1'b0, dc);
`ifdef SEQ_RD_CHECKSUM_EN
    check("full_checksum", checksum, 32'h1FE00);
`endif

    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      run_xfer(10'($urandom), 11'($urandom_range(1, 40)), 2, (k % 2) == 0, dc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
